mont_redc17: RTL
================

MONT_REDC17 -- requirements
Module: mont_redc17

Interface
REQ-001 SHALL have parameter W, default 17: operand width; the reduction radix is R = 2^W.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: t and n are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-006 SHALL have port t, input, 2W bits: product to reduce, i.e. the registered 34-bit multiplier output.
REQ-007 SHALL have port n, input, W bits: modulus.
REQ-008 SHALL have port out_valid, output, 1 bit: res and err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port res, output, W bits: t·R^-1 mod n, fully reduced.
REQ-011 SHALL have port err, output, 1 bit: the accepted operands violated the preconditions.

Function
REQ-012 SHALL use states IDLE, RUN, FIX and DONE; in_ready = (state==IDLE), combinational from state only.
REQ-013 SHALL accept an input on a rising edge with in_valid && in_ready, capturing t and n internally; later input changes SHALL NOT affect the transaction.
REQ-014 SHALL, at accept, check validity: valid iff n[0]==1 AND t[2W-1:W] < n, which is equivalent to t < n·2^W.
REQ-015 SHALL, for an invalid input, go IDLE->DONE with res=0, err=1 and out_valid=1 after the accept edge.
REQ-016 SHALL, for a valid input, go IDLE->RUN with a 2W+1-bit accumulator acc=t and iteration counter cnt=0.
REQ-017 SHALL, on each RUN edge, set acc <= (acc + (acc[0] ? n : 0)) >> 1 and cnt <= cnt+1; the addition SHALL be computed at 2W+1 bits without overflow.
REQ-018 SHALL move RUN->FIX on the edge that performs the W-th iteration, i.e. when cnt==W-1 before that edge.
REQ-019 SHALL, on the FIX edge, set res <= (acc >= n) ? acc-n : acc[W-1:0], err <= 0, out_valid <= 1, and go to DONE; acc < 2n SHALL hold at FIX, so res < n.
REQ-020 SHALL, for a valid input, assert out_valid after rising edge W+1 following the accept edge: 18 edges at W=17.
REQ-021 SHALL hold res, err and out_valid stable in DONE until an edge with out_ready=1; on that edge it SHALL return to IDLE with out_valid=0.
REQ-022 SHALL keep in_ready=0 in DONE, so a new input is accepted at the earliest one edge after the output handshake; at most one transaction is in flight.
REQ-023 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-024 SHALL treat n=1 as valid only when t[2W-1:W]==0, and SHALL then return res=0, err=0.
REQ-025 SHALL give t=0 with a valid n the result res=0, err=0.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force state=IDLE, out_valid=0, res=0, err=0, acc=0 and cnt=0.
REQ-027 SHALL, on rst asserted mid-RUN, FIX or DONE, abort the transaction with no output handshake; after release in_ready=1 in the first cycle.

Verification
REQ-028 Valid reduction: n=131071, t=5·2^17 -> out_valid 18 edges after accept, res=5, err=0.
REQ-029 Small odd modulus: n=3, t=1 -> res=2, err=0; n=3, t=0 -> res=0.
REQ-030 Error cases: n=4, t=7 -> out_valid one edge after accept, res=0, err=1; n=3, t=3·2^17 -> err=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> res and out_valid held; in_valid held high -> no accept until one edge after the out_ready handshake.
REQ-032 Reset at RUN iteration 9 -> out_valid never rises, in_ready=1 after release; the next transaction (n=131071, t=2^17) -> res=1.
REQ-033 Random: 10k valid (odd n, t < n·2^17) transactions with random out_ready -> res equals the reference model t·2^-17 mod n, and res < n.

Source files
------------

// File: rtl/mont_redc17.sv
// Bit-serial Montgomery reduction: res = t * 2^-W mod n for odd n and t < n * 2^W.
// One operand pair is in flight at a time; the result is held until the consumer takes it.
module mont_redc17 #(
  parameter int unsigned W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] t,
  input  logic [W-1:0]   n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   res,
  output logic           err
);

  localparam int unsigned AW = 2 * W + 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    res_q, res_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   sum_c;
  logic            ok_c;

  // Accumulator plus n when odd; the extra top bit absorbs the carry
  assign sum_c = acc_q + (acc_q[0] ? AW'(n_q) : AW'(0));

  // Preconditions: odd modulus and upper half of t below n (t < n * 2^W)
  assign ok_c = n[0] && (t[2*W-1:W] < n);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign err       = err_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      res_q       <= res_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    res_d       = res_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d = n;
          if (ok_c) begin
            acc_d   = AW'(t);
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            res_d       = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        acc_d = sum_c >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // acc < 2n here, so a single conditional subtract fully reduces it
        if (acc_q >= AW'(n_q)) begin
          res_d = W'(acc_q - AW'(n_q));
        end else begin
          res_d = acc_q[W-1:0];
        end
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
